// File: rtl/pdm_window_decimator_if.sv
// ---------------------------------------------------------------------------
// pdm_window_decimator_if
//   PCM output handshake of the PDM window decimator.
//
//   Signals:
//     pcm_out   [OUT_W]  decimated sample (latest completed window)
//     pcm_valid          pcm_out holds an unacknowledged sample
//     overrun            sticky: a sample completed while the previous one
//                        was still unacknowledged
//     pcm_ack            consumer accepts pcm_out while pcm_valid=1
//
//   Modports:
//     master  - the decimator (drives the sample, receives the ack)
//     slave   - the consumer  (receives the sample, drives the ack)
// ---------------------------------------------------------------------------
interface pdm_window_decimator_if #(
  parameter int OUT_W = 5
);
  logic [OUT_W-1:0] pcm_out;
  logic             pcm_valid;
  logic             overrun;
  logic             pcm_ack;

  modport master (
    output pcm_out,
    output pcm_valid,
    output overrun,
    input  pcm_ack
  );

  modport slave (
    input  pcm_out,
    input  pcm_valid,
    input  overrun,
    output pcm_ack
  );
endinterface

// File: rtl/pdm_window_decimator.sv
// ---------------------------------------------------------------------------
// pdm_window_decimator
//   Turns a 1-bit PDM stream back into PCM words. Ones are counted over a
//   fixed window of 2^WIN_LOG2 clocks (boxcar / first-order CIC) and the
//   count is scaled down to OUT_W bits, saturating at 2^OUT_W-1. With the
//   default 64-clock window and 5-bit output, a generator level L reads
//   back as L.
//
//   Parameters:
//     WIN_LOG2  log2 of the window length N (must be >= OUT_W)
//     OUT_W     PCM output width
//
//   Ports:
//     clk     in   system clock, rising edge
//     reset   in   asynchronous active-low reset
//     en      in   1 = run; 0 = idle with window state cleared
//     align   in   1-cycle pulse restarting the window (RUN only)
//     pdm_in  in   PDM bitstream
//     busy    out  decimator is in RUN
//     pcm     master side of pdm_window_decimator_if
//                  (pcm_out, pcm_valid, overrun out; pcm_ack in)
//
//   Build option:
//     PDM_WINDOW_DECIMATOR_SYNC_EN  when defined, pdm_in and align each pass
//     through a 2-flop synchronizer first (all timing shifts by 2 clocks);
//     when undefined they are used directly with no added latency.
// ---------------------------------------------------------------------------
module pdm_window_decimator #(
  parameter int WIN_LOG2 = 6,
  parameter int OUT_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  align,
  input  logic                  pdm_in,
  output logic                  busy,
  pdm_window_decimator_if.master pcm
);

  localparam int unsigned       SHIFT   = WIN_LOG2 - OUT_W;
  localparam logic [WIN_LOG2:0] OUT_MAX = (WIN_LOG2 + 1)'((1 << OUT_W) - 1);

  // Scale a window count (0..N) to OUT_W bits. Only the all-ones window
  // (count == N) can exceed the output range, so it is clipped.
  function automatic logic [OUT_W-1:0] sat_scale(input logic [WIN_LOG2:0] sum);
    logic [WIN_LOG2:0] scaled;
    scaled = sum >> SHIFT;
    if (scaled > OUT_MAX) begin
      sat_scale = '1;
    end else begin
      sat_scale = scaled[OUT_W-1:0];
    end
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic pdm_b;
  logic align_b;

`ifdef PDM_WINDOW_DECIMATOR_SYNC_EN
  // ---- stage p0/p1: input synchronizers ----
  logic pdm_p0, pdm_p1;
  logic align_p0, align_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pdm_p0   <= 1'b0;
      pdm_p1   <= 1'b0;
      align_p0 <= 1'b0;
      align_p1 <= 1'b0;
    end else begin
      pdm_p0   <= pdm_in;
      pdm_p1   <= pdm_p0;
      align_p0 <= align;
      align_p1 <= align_p0;
    end
  end

  assign pdm_b   = pdm_p1;
  assign align_b = align_p1;
`else
  assign pdm_b   = pdm_in;
  assign align_b = align;
`endif

  state_t                state_q, state_d;
  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic [WIN_LOG2-1:0]   phase_q, phase_d;
  logic [OUT_W-1:0]      pcm_out_q, pcm_out_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [WIN_LOG2:0]     sum;
  logic                  done;

  // ---- window accumulation / handshake ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      pcm_out_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      pcm_out_q <= pcm_out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    pcm_out_d = pcm_out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    done      = 1'b0;
    // The final bit of a window is folded in here rather than stored, so
    // cnt never needs to hold N itself.
    sum       = {1'b0, cnt_q} + (WIN_LOG2 + 1)'(pdm_b);

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = '0;
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Dropping en outranks align, which outranks window completion.
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = '0;
        end else if (align_b) begin
          cnt_d   = '0;
          phase_d = '0;
        end else if (phase_q == '1) begin
          done    = 1'b1;
          cnt_d   = '0;
          phase_d = '0;
        end else begin
          cnt_d   = cnt_q + WIN_LOG2'(pdm_b);
          phase_d = phase_q + WIN_LOG2'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A completing word always wins over an ack: the consumer sees the new
    // word on the same edge it took the old one.
    if (done) begin
      pcm_out_d = sat_scale(sum);
      valid_d   = 1'b1;
      if (valid_q && !pcm.pcm_ack) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && pcm.pcm_ack) begin
      valid_d = 1'b0;
    end
  end

  assign busy          = (state_q == RUN);
  assign pcm.pcm_out   = pcm_out_q;
  assign pcm.pcm_valid = valid_q;
  assign pcm.overrun   = overrun_q;

endmodule

// File: doc/pdm_window_decimator.md
Name: pdm_window_decimator

Overview:
- Downstream consumer of the 5-bit-level PDM generator: turns its 1-bit PDM stream back into PCM words.
- Counts ones over a fixed window of 2^WIN_LOG2 clocks (boxcar / first-order CIC) and scales the count to OUT_W bits.
- Presents each word through a valid/ack handshake; an overrun flag records lost words.
- With defaults (64-clock window, 5-bit out), it closes the loop on the generator's 64-clock level period, so a generator level L reads back as L.

Parameters:
WIN_LOG2, 6, log2 of window length N = 2^WIN_LOG2 clocks; must be >= OUT_W
OUT_W, 5, PCM output width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  1 = run; 0 = idle, window state cleared
align  input  1  1-cycle pulse restarting the window (tie to generator write_en)
pdm_in  input  1  PDM bitstream from generator
pcm_ack  input  1  consumer accepts pcm_out when pcm_valid=1
pcm_out  output  OUT_W  decimated sample
pcm_valid  output  1  pcm_out holds an unacknowledged sample
overrun  output  1  sticky: a sample completed while the previous one was unacknowledged
busy  output  1  state == RUN

Behaviour:
- Reset (reset=0, async):
  - pcm_out=0, pcm_valid=0, overrun=0, busy=0.
  - Internal ones-count cnt=0, phase=0, state=IDLE.
  - Release is synchronous to clk.
- States:
  - IDLE: en=1 -> RUN, with cnt=0 and phase=0. The first pdm bit is counted on the edge after en is seen high.
  - RUN: en=0 -> IDLE. cnt and phase are cleared; pcm_out, pcm_valid and overrun are held.
- RUN, each edge, with b = sampled pdm bit:
  - If phase != N-1: cnt <= cnt + b; phase <= phase + 1.
  - If phase == N-1:
    - sum = cnt + b, range 0..N, width WIN_LOG2+1.
    - pcm_out <= min(sum >> (WIN_LOG2-OUT_W), 2^OUT_W - 1).
    - pcm_valid <= 1.
    - If pcm_valid=1 and pcm_ack=0 on that same edge: overrun <= 1.
    - cnt <= 0; phase <= 0.
- Latency: pcm_valid rises on the same edge that samples bit N of the window.
- Handshake:
  - pcm_valid=1 and pcm_ack=1 on an edge with no completion -> pcm_valid <= 0.
  - Completion and ack on the same edge -> pcm_valid stays 1 with the new word; no overrun.
  - An unacked sample is overwritten by the newer word; pcm_out always shows the latest.
  - pcm_ack while pcm_valid=0 is ignored.
- align (RUN only):
  - cnt <= 0, phase <= 0; the current bit is discarded; no sample is emitted.
  - align has priority over completion on the same edge.
  - align in IDLE is ignored.
- overrun clears only on reset.
- en=0 on the completion edge: IDLE wins and no sample is emitted.
- Saturation: sum=N (all ones) with default parameters gives 64>>1 = 32, clipped to 31.

Optional Feature:
- Macro: PDM_WINDOW_DECIMATOR_SYNC_EN.
- Defined:
  - pdm_in and align each pass through a 2-flop synchronizer, reset to 0, before use.
  - Every timing above shifts by 2 clocks relative to the pins.
  - For use when the PDM source is off-chip or from another clock domain.
- Undefined: pdm_in and align are used directly (same-clock generator); zero added latency.

Test Plan:
- Reset, then en=1, pdm_in constant 0 for 64 clocks -> pcm_valid rises on the 64th counting edge, pcm_out=0; ack -> pcm_valid=0 next edge.
- pdm_in constant 1, 64 clocks -> pcm_out=31 (saturated), overrun=0.
- Generator chained upstream, align=write_en, level 0x08 then 0x1a, 64 clocks each -> pcm_out=0x08, then 0x1a.
- pdm_in alternating 1,0 with pcm_ack held 0 for 2 windows -> second completion sets overrun=1, pcm_out=16, pcm_valid=1; ack on the 3rd completion edge -> pcm_valid stays 1, overrun unchanged.
- Mid-window, 30 clocks of ones, then align pulse, then 64 clocks of zeros -> single sample pcm_out=0, no sample before it.
- reset pulsed low for half a clock mid-window -> all outputs 0 immediately (async); next full window after release emits a correct value.
